// File: rtl/dataint_crc_pkg.sv
// Shared types and helpers for the receive-side CRC checker.
package dataint_crc_pkg;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_RUN,
        ST_STATUS
    } state_t;

    function automatic int crc_bytes(input int width);
        return width / 8;
    endfunction

    // Reverses the low 'width' bits of v; the result is right-aligned.
    function automatic logic [31:0] bit_rev(input logic [31:0] v, input int width);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r >> (32 - width);
    endfunction

endpackage

// File: rtl/dataint_crc_xor_shift.sv
// One bit of a normal-form (MSB-first) LFSR CRC update.
module dataint_crc_xor_shift #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] crc_in,
    input  logic [WIDTH-1:0] poly,
    input  logic             bit_in,
    output logic [WIDTH-1:0] crc_out
);

    logic fb;

    assign fb      = crc_in[WIDTH-1] ^ bit_in;
    assign crc_out = (crc_in << 1) ^ (fb ? poly : '0);

endmodule

// File: rtl/dataint_crc_checker.sv
// Receive-side CRC checker: strips the trailing CRC field via a delay line,
// recomputes the CRC over the payload and reports a held status.
module dataint_crc_checker
    import dataint_crc_pkg::*;
#(
    parameter int          CRC_WIDTH     = 32,
    parameter logic [31:0] POLY          = 32'h04C11DB7,
    parameter logic [31:0] INIT          = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT        = 32'h00000000,
    parameter bit          REFIN         = 1'b0,
    parameter bit          REFOUT        = 1'b0,
    parameter bit          CRC_MSB_FIRST = 1'b1,
    parameter int          LEN_WIDTH     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [7:0]           i_data,
    input  logic                 i_last,
    output logic                 o_status_valid,
    input  logic                 i_status_ready,
    output logic                 o_crc_ok,
    output logic                 o_frame_err,
    output logic [CRC_WIDTH-1:0] o_crc_calc,
    output logic [CRC_WIDTH-1:0] o_crc_rx,
    output logic [LEN_WIDTH-1:0] o_payload_len
);

    localparam int CRC_BYTES = crc_bytes(CRC_WIDTH);
    localparam int CW        = $clog2(CRC_BYTES + 1);

    state_t               state, state_nxt;
    logic [CRC_WIDTH-1:0] crc_reg, crc_upd, dly, dly_nxt, rx_asm, calc_fin;
    logic [CW-1:0]        fill_cnt;
    logic [LEN_WIDTH-1:0] len, len_upd;
    logic [7:0]           evict_byte;
    logic [31:0]          rev_full;
    logic                 acc, evict, short_frame;

    assign o_ready     = ~i_rst & (state != ST_STATUS);
    assign acc         = i_valid & o_ready;
    assign evict       = acc && (fill_cnt == CW'(CRC_BYTES));
    assign short_frame = fill_cnt < CW'(CRC_BYTES - 1);
    assign dly_nxt     = (dly << 8) | CRC_WIDTH'(i_data);
    assign evict_byte  = dly[CRC_WIDTH-1 -: 8];

    // Per-byte CRC update as a chain of eight single-bit stages.
    logic [8:0][CRC_WIDTH-1:0] chain;
    assign chain[0] = crc_reg;

    for (genvar i = 0; i < 8; i++) begin : g_stage
        dataint_crc_xor_shift #(.WIDTH(CRC_WIDTH)) u_stage (
            .crc_in  (chain[i]),
            .poly    (POLY[CRC_WIDTH-1:0]),
            .bit_in  (REFIN ? evict_byte[i] : evict_byte[7-i]),
            .crc_out (chain[i+1])
        );
    end

    assign crc_upd  = evict ? chain[8] : crc_reg;
    assign len_upd  = (evict && len != '1) ? len + 1'b1 : len;
    assign rev_full = bit_rev(32'(crc_upd), CRC_WIDTH);
    assign calc_fin = (REFOUT ? rev_full[CRC_WIDTH-1:0] : crc_upd) ^ XOROUT[CRC_WIDTH-1:0];

    // Oldest byte in the delay line is the first CRC byte received.
    for (genvar k = 0; k < CRC_BYTES; k++) begin : g_rx
        assign rx_asm[8*k +: 8] = CRC_MSB_FIRST ? dly_nxt[8*k +: 8]
                                                : dly_nxt[8*(CRC_BYTES-1-k) +: 8];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_FILL;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL: begin
                if (acc) begin
                    if (i_last)                              state_nxt = ST_STATUS;
                    else if (fill_cnt == CW'(CRC_BYTES - 1)) state_nxt = ST_RUN;
                end
            end
            ST_RUN:    if (acc && i_last)  state_nxt = ST_STATUS;
            ST_STATUS: if (i_status_ready) state_nxt = ST_FILL;
            default:   state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            crc_reg        <= INIT[CRC_WIDTH-1:0];
            dly            <= '0;
            fill_cnt       <= '0;
            len            <= '0;
            o_status_valid <= 1'b0;
            o_crc_ok       <= 1'b0;
            o_frame_err    <= 1'b0;
            o_crc_calc     <= '0;
            o_crc_rx       <= '0;
            o_payload_len  <= '0;
        end else if (state == ST_STATUS) begin
            if (i_status_ready) begin
                o_status_valid <= 1'b0;
                crc_reg        <= INIT[CRC_WIDTH-1:0];
                dly            <= '0;
                fill_cnt       <= '0;
                len            <= '0;
            end
        end else if (acc) begin
            dly     <= dly_nxt;
            crc_reg <= crc_upd;
            len     <= len_upd;
            if (fill_cnt != CW'(CRC_BYTES)) fill_cnt <= fill_cnt + 1'b1;
            if (i_last) begin
                o_status_valid <= 1'b1;
                o_frame_err    <= short_frame;
                o_crc_ok       <= ~short_frame & (calc_fin == rx_asm);
                o_crc_calc     <= calc_fin;
                o_crc_rx       <= rx_asm;
                o_payload_len  <= len_upd;
            end
        end
    end

endmodule

// File: tb/tb_dataint_crc_checker.sv
// Directed + randomized bench: CRC-32/MPEG-2 instance (MSB-first field) and
// CRC-16/CCITT-FALSE instance (LSB-first field) against a bytewise CRC model.
module tb_dataint_crc_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, l0, sr0, r0, sv0, ok0, fe0;
    logic [7:0]  d0;
    logic [31:0] calc0, rx0;
    logic [15:0] len0;
    logic        v1, l1, sr1, r1, sv1, ok1, fe1;
    logic [7:0]  d1;
    logic [15:0] calc1, rx1;
    logic [15:0] len1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        sv, ok, fe, rdy;
        logic [31:0] calc, rx, len;
    } snap_t;

    always #5 clk = ~clk;

    dataint_crc_checker u_dut32 (
        .i_clk(clk), .i_rst(rst), .i_valid(v0), .o_ready(r0), .i_data(d0), .i_last(l0),
        .o_status_valid(sv0), .i_status_ready(sr0), .o_crc_ok(ok0), .o_frame_err(fe0),
        .o_crc_calc(calc0), .o_crc_rx(rx0), .o_payload_len(len0)
    );

    dataint_crc_checker #(
        .CRC_WIDTH(16), .POLY(32'h1021), .INIT(32'hFFFF), .CRC_MSB_FIRST(1'b0)
    ) u_dut16 (
        .i_clk(clk), .i_rst(rst), .i_valid(v1), .o_ready(r1), .i_data(d1), .i_last(l1),
        .o_status_valid(sv1), .i_status_ready(sr1), .o_crc_ok(ok1), .o_frame_err(fe1),
        .o_crc_calc(calc1), .o_crc_rx(rx1), .o_payload_len(len1)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic snap_t snap(input int sel);
        snap_t s;
        if (sel == 0) begin
            s.sv = sv0; s.ok = ok0; s.fe = fe0; s.rdy = r0;
            s.calc = calc0; s.rx = rx0; s.len = 32'(len0);
        end else begin
            s.sv = sv1; s.ok = ok1; s.fe = fe1; s.rdy = r1;
            s.calc = 32'(calc1); s.rx = 32'(rx1); s.len = 32'(len1);
        end
        return s;
    endfunction

    // Textbook bytewise CRC (normal form, no reflection, XOROUT = 0, INIT = all ones).
    function automatic logic [31:0] model(input int sel, input logic [7:0] pl[$]);
        int          w    = (sel == 0) ? 32 : 16;
        logic [31:0] poly = (sel == 0) ? 32'h04C11DB7 : 32'h1021;
        logic [31:0] mask = (sel == 0) ? 32'hFFFFFFFF : 32'h0000FFFF;
        logic [31:0] c    = mask;
        foreach (pl[i]) begin
            c = c ^ ({24'h0, pl[i]} << (w - 8));
            repeat (8) c = c[w-1] ? (((c << 1) ^ poly) & mask) : ((c << 1) & mask);
        end
        return c;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic l);
        if (sel == 0) begin v0 = v; d0 = d; l0 = l; end
        else          begin v1 = v; d1 = d; l1 = l; end
    endtask

    task automatic set_sr(input int sel, input logic val);
        if (sel == 0) sr0 = val;
        else          sr1 = val;
    endtask

    // Offers a byte at a negedge and returns after the posedge that takes it.
    task automatic push(input int sel, input logic [7:0] b, input bit last, input bit gaps);
        int    n = 0;
        snap_t s;
        if (gaps && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            drive(sel, 1'b0, 8'h00, 1'b0);
        end
        @(negedge clk);
        drive(sel, 1'b1, b, last);
        s = snap(sel);
        while (!s.rdy && n < 20) begin
            @(negedge clk);
            n++;
            s = snap(sel);
        end
        if (n == 20) chk("ready_timeout", 32'(s.rdy), 32'd1);
        @(posedge clk);
    endtask

    task automatic push_crc(input int sel, input logic [31:0] rxv, input bit gaps);
        int nb = (sel == 0) ? 4 : 2;
        for (int k = 0; k < nb; k++) begin
            logic [7:0] b;
            b = (sel == 0) ? rxv[8*(nb-1-k) +: 8] : rxv[8*k +: 8];
            push(sel, b, k == nb - 1, gaps);
        end
    endtask

    task automatic status_check(input int sel, input string tag, input bit e_ok, input bit e_fe,
                                input logic [31:0] e_calc, input logic [31:0] e_rx,
                                input int e_len, input bit full);
        snap_t s = snap(sel);
        chk({tag, "_valid"}, 32'(s.sv), 32'd1);
        chk({tag, "_ready_low"}, 32'(s.rdy), 32'd0);
        chk({tag, "_ok"}, 32'(s.ok), 32'(e_ok));
        chk({tag, "_frame_err"}, 32'(s.fe), 32'(e_fe));
        chk({tag, "_len"}, s.len, 32'(e_len));
        if (full) begin
            chk({tag, "_calc"}, s.calc, e_calc);
            chk({tag, "_rx"}, s.rx, e_rx);
        end
    endtask

    task automatic send_frame(input int sel, input string tag, input logic [7:0] pl[$],
                              input logic [31:0] rxv, input bit gaps);
        logic [31:0] crc = model(sel, pl);
        foreach (pl[i]) push(sel, pl[i], 1'b0, gaps);
        push_crc(sel, rxv, gaps);
        @(negedge clk);
        drive(sel, 1'b0, 8'h00, 1'b0);
        status_check(sel, tag, crc == rxv, 1'b0, crc, rxv, pl.size(), 1'b1);
    endtask

    task automatic handshake(input int sel, input string tag);
        snap_t s;
        @(negedge clk);
        drive(sel, 1'b0, 8'h00, 1'b0);
        set_sr(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_sr(sel, 1'b0);
        s = snap(sel);
        chk({tag, "_hs_valid_clr"}, 32'(s.sv), 32'd0);
        chk({tag, "_hs_ready"}, 32'(s.rdy), 32'd1);
    endtask

    initial begin
        logic [7:0]  q[$];
        logic [7:0]  q2[$];
        logic [7:0]  qs[$];
        logic [7:0]  pl[$];
        logic [31:0] crc, rxv, e32;
        snap_t       s;

        rst = 1'b1;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        sr0 = 1'b0; sr1 = 1'b0;
        repeat (3) @(negedge clk);
        s = snap(0);
        chk("reset_valid", 32'(s.sv), 32'd0);
        chk("reset_ok", 32'(s.ok), 32'd0);
        chk("reset_fe", 32'(s.fe), 32'd0);
        chk("reset_calc", s.calc, 32'd0);
        chk("reset_rx", s.rx, 32'd0);
        chk("reset_len", s.len, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(r0), 32'd1);

        q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        chk("model_check_mpeg2", model(0, q), 32'h0376E6E7);
        send_frame(0, "mpeg2", q, 32'h0376E6E7, 1'b0);
        chk("mpeg2_calc_const", calc0, 32'h0376E6E7);
        handshake(0, "mpeg2");

        q2 = q;
        q2[4] = 8'h36;
        send_frame(0, "corrupt", q2, 32'h0376E6E7, 1'b0);
        handshake(0, "corrupt");

        send_frame(1, "ccitt", q, 32'h000029B1, 1'b0);
        chk("ccitt_calc_const", 32'(calc1), 32'h000029B1);
        handshake(1, "ccitt");

        for (int n = 1; n <= 3; n++) begin
            for (int i = 0; i < n; i++) push(0, 8'(8'hA0 + i), i == n - 1, 1'b0);
            @(negedge clk);
            drive(0, 1'b0, 8'h00, 1'b0);
            status_check(0, "short", 1'b0, 1'b1, 32'd0, 32'd0, 0, 1'b0);
            handshake(0, "short");
        end

        qs = {};
        send_frame(0, "zero_payload", qs, 32'hFFFFFFFF, 1'b0);
        handshake(0, "zero_payload");

        // Held status under backpressure with the next frame's first byte waiting.
        send_frame(0, "bp", q, 32'h0376E6E7, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, q[0], 1'b0);
        repeat (5) begin
            @(negedge clk);
            s = snap(0);
            chk("bp_ready_low", 32'(s.rdy), 32'd0);
            chk("bp_valid_held", 32'(s.sv), 32'd1);
            chk("bp_calc_held", s.calc, 32'h0376E6E7);
            chk("bp_ok_held", 32'(s.ok), 32'd1);
            chk("bp_len_held", s.len, 32'd9);
        end
        sr0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        sr0 = 1'b0;
        chk("bp_release_ready", 32'(r0), 32'd1);
        chk("bp_release_valid", 32'(sv0), 32'd0);
        @(posedge clk);
        for (int i = 1; i < 9; i++) push(0, q[i], 1'b0, 1'b0);
        push_crc(0, 32'h0376E6E7, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 1'b0);
        status_check(0, "bp_next", 1'b1, 1'b0, 32'h0376E6E7, 32'h0376E6E7, 9, 1'b1);
        handshake(0, "bp_next");
        q2 = '{8'h01, 8'h02, 8'h03};
        send_frame(0, "b2b", q2, model(0, q2), 1'b0);
        handshake(0, "b2b");

        // Reset in the middle of a 6-byte payload, then a clean frame.
        for (int i = 0; i < 3; i++) push(0, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_no_status", 32'(sv0), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_after_valid", 32'(sv0), 32'd0);
        chk("midrst_after_ready", 32'(r0), 32'd1);
        pl = {};
        for (int i = 0; i < 6; i++) pl.push_back(8'($urandom_range(0, 255)));
        send_frame(0, "post_rst", pl, model(0, pl), 1'b0);
        handshake(0, "post_rst");

        for (int it = 0; it < 40; it++) begin
            int sel = $urandom_range(0, 1);
            int w   = (sel == 0) ? 32 : 16;
            pl = {};
            repeat ($urandom_range(0, 10)) pl.push_back(8'($urandom_range(0, 255)));
            crc = model(sel, pl);
            e32 = ($urandom_range(0, 2) == 0) ? (32'h1 << $urandom_range(0, w - 1)) : 32'h0;
            rxv = crc ^ e32;
            send_frame(sel, "rand", pl, rxv, 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("rand_held_calc", snap(sel).calc, crc);
            end
            handshake(sel, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
